id_ex_hazard_stage: RTL and testbench
=====================================

ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 Parameters: none; register-address width fixed at 5 bits, two issue slots (32-bit slot "_32", 16-bit slot "_16").
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rs1_32_id, rs2_32_id, rs1_16_id, rs2_16_id  input  5 each  ID-stage source registers per slot.
REQ-005 rd_32_id, rd_16_id  input  5 each  ID-stage destination registers.
REQ-006 regWrite_32_id, regWrite_16_id, memRead_32_id, memRead_16_id  input  1 each  ID-stage control bits.
REQ-007 valid_32_id, valid_16_id  input  1 each  slot holds a real instruction.
REQ-008 flush  input  1  branch-taken kill of the ID bundle.
REQ-009 rs1_32, rs2_32, rs1_16, rs2_16  output  5 each  registered EX-stage sources, to the forwarding unit.
REQ-010 rd_32_ex, rd_16_ex  output  5 each  registered EX-stage destinations.
REQ-011 regWrite_32_ex, regWrite_16_ex, memRead_32_ex, memRead_16_ex, valid_32_ex, valid_16_ex  output  1 each  registered EX-stage control.
REQ-012 stall  output  1  combinational; holds PC and IF/ID upstream.
REQ-013 stall_count  output  16  load-use stall counter (REQ-027).

Function
REQ-014 Hazard (combinational): for each EX slot X in {32,16} with memRead_X_ex=1, valid_X_ex=1, rd_X_ex!=0, match when rd_X_ex equals rs1 or rs2 of any ID slot whose valid_Y_id=1.
REQ-015 stall SHALL equal (any match) AND NOT flush.
REQ-016 Every edge, in priority rst > flush > stall > load: EX register takes exactly one action.
REQ-017 flush=1: all EX fields cleared (bubble: rd/rs=0, regWrite/memRead/valid=0).
REQ-018 stall=1: EX registers loaded with bubble; ID inputs ignored (upstream holds them).
REQ-019 Otherwise: all ID inputs copied to EX outputs; slots with valid_Y_id=0 load as bubble for that slot only.
REQ-020 Latency: ID to EX exactly one cycle; a stalled bundle enters EX exactly one cycle later provided no new hazard or flush.
REQ-021 A load-use stall SHALL last exactly one cycle: after the bubble, the load is in MEM and its result is forwarded (MEM select).
REQ-022 rd=0 never causes stall; regWrite to r0 is passed through unchanged (forwarding unit masks r0).
REQ-023 Both EX slots loading same rd: both passed; 16-slot priority resolved downstream.
REQ-024 Simultaneous hazard on both slots or both sources: single stall cycle, no double count.

Reset
REQ-025 rst=1 at edge: all EX outputs 0, stall_count 0; stall reads 0 while EX holds bubble.
REQ-026 rst mid-stall: stall deasserts the cycle after reset edge; no bundle retained.

Configuration
REQ-027 Macro STALL_COUNT_EN: when defined, stall_count increments by 1 each edge with stall=1 and rst=0, saturating at 16'hFFFF; when undefined, stall_count SHALL be constant 0 and no counter flops exist.

Verification
REQ-028 EX: memRead_32_ex=1, rd_32_ex=5; ID: rs1_16_id=5 valid -> stall=1 one cycle, EX bubble, next edge rs1_16=5 loaded, stall=0.
REQ-029 Same as REQ-028 but flush=1 -> stall=0, EX all zero after edge.
REQ-030 EX load rd_16_ex=0; ID rs2_32_id=0 -> stall=0, bundle passes in one cycle.
REQ-031 Back-to-back independent bundles with regWrite=1, rd=3,4 -> EX mirrors ID with one-cycle delay, stall never asserted.
REQ-032 STALL_COUNT_EN defined: 3 load-use stalls then rst -> stall_count 3 then 0; undefined -> stays 0.
REQ-033 rst asserted during stall cycle -> all outputs 0 next cycle, stall=0.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register for a dual-issue (32-bit + 16-bit slot) core with load-use hazard detection.
// Optional macro STALL_COUNT_EN adds a saturating 16-bit count of load-use stall cycles.
module id_ex_hazard_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_32_id,
    input  logic [4:0] rs2_32_id,
    input  logic [4:0] rs1_16_id,
    input  logic [4:0] rs2_16_id,
    input  logic [4:0] rd_32_id,
    input  logic [4:0] rd_16_id,
    input  logic       regWrite_32_id,
    input  logic       regWrite_16_id,
    input  logic       memRead_32_id,
    input  logic       memRead_16_id,
    input  logic       valid_32_id,
    input  logic       valid_16_id,
    input  logic       flush,
    output logic [4:0] rs1_32,
    output logic [4:0] rs2_32,
    output logic [4:0] rs1_16,
    output logic [4:0] rs2_16,
    output logic [4:0] rd_32_ex,
    output logic [4:0] rd_16_ex,
    output logic       regWrite_32_ex,
    output logic       regWrite_16_ex,
    output logic       memRead_32_ex,
    output logic       memRead_16_ex,
    output logic       valid_32_ex,
    output logic       valid_16_ex,
    output logic       stall,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       valid;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = slot_t'(18'd0);

    slot_t id_32_s;
    slot_t id_16_s;
    slot_t next_32_s;
    slot_t next_16_s;
    slot_t ex_32_r;
    slot_t ex_16_r;
    logic  stall_s;

    // A live EX load with a non-zero destination is the only producer that can cause a stall.
    function automatic logic is_load(input slot_t ex);
        return ex.valid && ex.mem_read && (ex.rd != 5'd0);
    endfunction

    function automatic logic rd_hits(input logic [4:0] rd, input slot_t src);
        return src.valid && ((rd == src.rs1) || (rd == src.rs2));
    endfunction

    assign id_32_s = {rs1_32_id, rs2_32_id, rd_32_id, regWrite_32_id, memRead_32_id, valid_32_id};
    assign id_16_s = {rs1_16_id, rs2_16_id, rd_16_id, regWrite_16_id, memRead_16_id, valid_16_id};

    // Load-use detection across both EX producers and both ID consumers; one flag however many match.
    always_comb begin
        stall_s = 1'b0;
        if (!flush) begin
            stall_s = (is_load(ex_32_r) && (rd_hits(ex_32_r.rd, id_32_s) || rd_hits(ex_32_r.rd, id_16_s)))
                   || (is_load(ex_16_r) && (rd_hits(ex_16_r.rd, id_32_s) || rd_hits(ex_16_r.rd, id_16_s)));
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next EX contents: bubble on flush or stall, otherwise per-slot copy of valid ID instructions.
    always_comb begin
        next_32_s = SLOT_BUBBLE;
        next_16_s = SLOT_BUBBLE;
        if (flush || stall_s) begin
            next_32_s = SLOT_BUBBLE;
            next_16_s = SLOT_BUBBLE;
        end else begin
            next_32_s = id_32_s.valid ? id_32_s : SLOT_BUBBLE;
            next_16_s = id_16_s.valid ? id_16_s : SLOT_BUBBLE;
        end
    end

    // EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_32_r <= SLOT_BUBBLE;
            ex_16_r <= SLOT_BUBBLE;
        end else begin
            ex_32_r <= next_32_s;
            ex_16_r <= next_16_s;
        end
    end

`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_r;

    // Saturating count of stall cycles, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 16'd0;
        end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`else
    assign stall_count = 16'd0;
`endif

    assign stall          = stall_s;
    assign rs1_32         = ex_32_r.rs1;
    assign rs2_32         = ex_32_r.rs2;
    assign rd_32_ex       = ex_32_r.rd;
    assign regWrite_32_ex = ex_32_r.reg_write;
    assign memRead_32_ex  = ex_32_r.mem_read;
    assign valid_32_ex    = ex_32_r.valid;
    assign rs1_16         = ex_16_r.rs1;
    assign rs2_16         = ex_16_r.rs2;
    assign rd_16_ex       = ex_16_r.rd;
    assign regWrite_16_ex = ex_16_r.reg_write;
    assign memRead_16_ex  = ex_16_r.mem_read;
    assign valid_16_ex    = ex_16_r.valid;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: directed scenarios then random bundles against a slot-level reference model.
module tb_id_ex_hazard_stage;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       v;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    slot_t id_s [2];
    slot_t ex_m [2];
    int exp_cnt = 0;
    int checks = 0;
    int errors = 0;

    logic [4:0] rs1_32, rs2_32, rs1_16, rs2_16, rd_32_ex, rd_16_ex;
    logic regWrite_32_ex, regWrite_16_ex, memRead_32_ex, memRead_16_ex, valid_32_ex, valid_16_ex;
    logic stall;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    id_ex_hazard_stage dut (
        .clk(clk), .rst(rst),
        .rs1_32_id(id_s[0].rs1), .rs2_32_id(id_s[0].rs2),
        .rs1_16_id(id_s[1].rs1), .rs2_16_id(id_s[1].rs2),
        .rd_32_id(id_s[0].rd), .rd_16_id(id_s[1].rd),
        .regWrite_32_id(id_s[0].rw), .regWrite_16_id(id_s[1].rw),
        .memRead_32_id(id_s[0].mr), .memRead_16_id(id_s[1].mr),
        .valid_32_id(id_s[0].v), .valid_16_id(id_s[1].v),
        .flush(flush),
        .rs1_32(rs1_32), .rs2_32(rs2_32), .rs1_16(rs1_16), .rs2_16(rs2_16),
        .rd_32_ex(rd_32_ex), .rd_16_ex(rd_16_ex),
        .regWrite_32_ex(regWrite_32_ex), .regWrite_16_ex(regWrite_16_ex),
        .memRead_32_ex(memRead_32_ex), .memRead_16_ex(memRead_16_ex),
        .valid_32_ex(valid_32_ex), .valid_16_ex(valid_16_ex),
        .stall(stall), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int y, input int rs1, input int rs2, input int rd,
                            input bit rw, input bit mr, input bit v);
        id_s[y] = {rs1[4:0], rs2[4:0], rd[4:0], rw, mr, v};
    endtask

    // Reference rule: a valid EX load to a non-zero register read by any valid ID slot stalls, unless flushed.
    function automatic logic model_stall();
        logic hit = 1'b0;
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                if (ex_m[x].mr && ex_m[x].v && ex_m[x].rd != 5'd0 && id_s[y].v &&
                    (ex_m[x].rd == id_s[y].rs1 || ex_m[x].rd == id_s[y].rs2))
                    hit = 1'b1;
        return hit && !flush;
    endfunction

    // One clock: check stall before the edge, advance the model, check EX after the edge.
    task automatic step(input string tag, input bit chk_stall);
        logic exp_stall;
        slot_t obs32, obs16;
        #1;
        exp_stall = model_stall();
        if (chk_stall) chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clk);
        for (int y = 0; y < 2; y++)
            ex_m[y] = (rst || flush || exp_stall || !id_s[y].v) ? slot_t'(18'd0) : id_s[y];
`ifdef STALL_COUNT_EN
        if (rst) exp_cnt = 0;
        else if (exp_stall && exp_cnt < 65535) exp_cnt++;
`endif
        #1;
        obs32 = {rs1_32, rs2_32, rd_32_ex, regWrite_32_ex, memRead_32_ex, valid_32_ex};
        obs16 = {rs1_16, rs2_16, rd_16_ex, regWrite_16_ex, memRead_16_ex, valid_16_ex};
        chk({tag, "_ex32"}, {14'd0, obs32}, {14'd0, ex_m[0]});
        chk({tag, "_ex16"}, {14'd0, obs16}, {14'd0, ex_m[1]});
        chk({tag, "_cnt"}, {16'd0, stall_count}, exp_cnt[31:0]);
    endtask

    initial begin
        ex_m[0] = '0; ex_m[1] = '0;
        set_slot(0, 0, 0, 0, 0, 0, 0);
        set_slot(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("reset", 1'b0);
        rst = 1'b0;
        step("idle", 1'b1);
        chk("idle_stall_zero", {31'd0, stall}, 32'd0);

        // Back-to-back independent bundles writing r3 and r4.
        set_slot(0, 1, 2, 3, 1, 0, 1); set_slot(1, 6, 7, 4, 1, 0, 1);
        step("b2b_a", 1'b1);
        chk("b2b_rd32", {27'd0, rd_32_ex}, 32'd3);
        set_slot(0, 3, 4, 4, 1, 0, 1); set_slot(1, 8, 9, 3, 1, 0, 1);
        step("b2b_b", 1'b1);
        chk("b2b_rd16", {27'd0, rd_16_ex}, 32'd3);

        // Load to r5 in slot 32, then slot 16 reads r5.
        set_slot(0, 1, 2, 5, 1, 1, 1); set_slot(1, 0, 0, 0, 0, 0, 0);
        step("ld", 1'b1);
        set_slot(0, 0, 0, 0, 0, 0, 0); set_slot(1, 5, 1, 6, 1, 0, 1);
        #1;
        chk("lu_stall_hi", {31'd0, stall}, 32'd1);
        step("lu_bubble", 1'b1);
        chk("lu_bubble_v16", {31'd0, valid_16_ex}, 32'd0);
        chk("lu_stall_lo", {31'd0, stall}, 32'd0);
        step("lu_load", 1'b1);
        chk("lu_rs1_16", {27'd0, rs1_16}, 32'd5);

        // Same hazard killed by flush.
        set_slot(0, 1, 2, 5, 1, 1, 1); set_slot(1, 0, 0, 0, 0, 0, 0);
        step("ld2", 1'b1);
        set_slot(0, 0, 0, 0, 0, 0, 0); set_slot(1, 5, 1, 6, 1, 0, 1);
        flush = 1'b1;
        step("flush", 1'b1);
        chk("flush_v16", {31'd0, valid_16_ex}, 32'd0);
        flush = 1'b0;

        // Load to r0 never stalls.
        set_slot(0, 0, 0, 0, 0, 0, 0); set_slot(1, 1, 1, 0, 1, 1, 1);
        step("ldr0", 1'b1);
        set_slot(0, 2, 0, 7, 1, 0, 1); set_slot(1, 0, 0, 0, 0, 0, 0);
        step("r0_pass", 1'b1);
        chk("r0_rd32", {27'd0, rd_32_ex}, 32'd7);

        // Both EX slots load, both ID slots depend: single stall cycle.
        set_slot(0, 1, 1, 9, 1, 1, 1); set_slot(1, 1, 1, 10, 1, 1, 1);
        step("dbl_ld", 1'b1);
        set_slot(0, 9, 10, 11, 1, 0, 1); set_slot(1, 10, 9, 12, 1, 0, 1);
        step("dbl_stall", 1'b1);
        step("dbl_load", 1'b1);

        // Reset asserted during a stall cycle.
        set_slot(0, 1, 2, 5, 1, 1, 1); set_slot(1, 0, 0, 0, 0, 0, 0);
        step("ld3", 1'b1);
        set_slot(0, 5, 0, 6, 1, 0, 1);
        rst = 1'b1;
        step("rst_stall", 1'b1);
        rst = 1'b0;
        chk("rst_stall_lo", {31'd0, stall}, 32'd0);
        chk("rst_valid32", {31'd0, valid_32_ex}, 32'd0);

        // Three load-use stalls, then reset clears the counter.
        for (int k = 0; k < 3; k++) begin
            set_slot(0, 1, 2, 8, 1, 1, 1); set_slot(1, 0, 0, 0, 0, 0, 0);
            step("cnt_ld", 1'b1);
            set_slot(0, 0, 0, 0, 0, 0, 0); set_slot(1, 3, 8, 4, 1, 0, 1);
            step("cnt_stall", 1'b1);
            set_slot(1, 0, 0, 0, 0, 0, 0);
            step("cnt_drain", 1'b1);
        end
`ifdef STALL_COUNT_EN
        chk("cnt_three", {16'd0, stall_count}, 32'd3);
`else
        chk("cnt_off", {16'd0, stall_count}, 32'd0);
`endif
        rst = 1'b1;
        step("cnt_rst", 1'b1);
        rst = 1'b0;
        chk("cnt_zero", {16'd0, stall_count}, 32'd0);

        // Random bundles over a narrow register range so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            for (int y = 0; y < 2; y++)
                set_slot(y, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0),
                         1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                         1'($urandom_range(3, 0) != 0));
            flush = ($urandom_range(7, 0) == 0);
            rst = ($urandom_range(31, 0) == 0);
            step("rand", 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
